// File: rtl/decode_ctrl_pipe_pkg.sv
// Shared constants and types for the RV32I decode-stage controller:
// immediate formats, major opcodes, control bundle and ID/EX register layout.
package decode_ctrl_pipe_pkg;

  typedef enum logic [2:0] {
    IMM_RTYPE = 3'd0,
    IMM_ITYPE = 3'd1,
    IMM_STYPE = 3'd2,
    IMM_BTYPE = 3'd3,
    IMM_UTYPE = 3'd4,
    IMM_JTYPE = 3'd5
  } imm_type_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic branch;
    logic jal;
    logic jalr;
    logic alu_src2_imm;
    logic illegal;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = ctrl_t'(8'h00);

  typedef struct packed {
    imm_type_e  imm_type;
    ctrl_t      ctrl;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       valid;
  } idex_t;

  localparam idex_t IDEX_BUBBLE = '{
    imm_type: IMM_RTYPE,
    ctrl:     CTRL_NONE,
    rd:       5'd0,
    rs1:      5'd0,
    rs2:      5'd0,
    valid:    1'b0
  };

  // A source only creates a dependency when the format actually reads it.
  function automatic logic src_match(input logic used, input logic [4:0] rs,
                                     input logic [4:0] rd);
    return used & (rs == rd);
  endfunction

endpackage

// File: rtl/decode_ctrl_pipe_opcode_decoder.sv
// Combinational opcode decode: immediate format, control bundle,
// source-register usage and illegal-opcode flag.
module decode_ctrl_pipe_opcode_decoder
  import decode_ctrl_pipe_pkg::*;
(
  input  logic [6:0] opcode_i,
  output logic [2:0] imm_type_o,
  output logic       reg_write_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       branch_o,
  output logic       jal_o,
  output logic       jalr_o,
  output logic       alu_src2_imm_o,
  output logic       illegal_o,
  output logic       rs1_used_o,
  output logic       rs2_used_o
);

  // Decode the major opcode into format select and control signals.
  always_comb begin
    imm_type_o     = IMM_RTYPE;
    reg_write_o    = 1'b0;
    mem_read_o     = 1'b0;
    mem_write_o    = 1'b0;
    branch_o       = 1'b0;
    jal_o          = 1'b0;
    jalr_o         = 1'b0;
    alu_src2_imm_o = 1'b0;
    illegal_o      = 1'b0;
    rs1_used_o     = 1'b0;
    rs2_used_o     = 1'b0;
    case (opcode_i)
      OPC_OP: begin
        imm_type_o  = IMM_RTYPE;
        reg_write_o = 1'b1;
        rs1_used_o  = 1'b1;
        rs2_used_o  = 1'b1;
      end
      OPC_OP_IMM: begin
        imm_type_o     = IMM_ITYPE;
        reg_write_o    = 1'b1;
        alu_src2_imm_o = 1'b1;
        rs1_used_o     = 1'b1;
      end
      OPC_LOAD: begin
        imm_type_o     = IMM_ITYPE;
        reg_write_o    = 1'b1;
        mem_read_o     = 1'b1;
        alu_src2_imm_o = 1'b1;
        rs1_used_o     = 1'b1;
      end
      OPC_STORE: begin
        imm_type_o     = IMM_STYPE;
        mem_write_o    = 1'b1;
        alu_src2_imm_o = 1'b1;
        rs1_used_o     = 1'b1;
        rs2_used_o     = 1'b1;
      end
      OPC_BRANCH: begin
        imm_type_o = IMM_BTYPE;
        branch_o   = 1'b1;
        rs1_used_o = 1'b1;
        rs2_used_o = 1'b1;
      end
      OPC_LUI, OPC_AUIPC: begin
        imm_type_o     = IMM_UTYPE;
        reg_write_o    = 1'b1;
        alu_src2_imm_o = 1'b1;
      end
      OPC_JAL: begin
        imm_type_o  = IMM_JTYPE;
        reg_write_o = 1'b1;
        jal_o       = 1'b1;
      end
      OPC_JALR: begin
        imm_type_o     = IMM_ITYPE;
        reg_write_o    = 1'b1;
        jalr_o         = 1'b1;
        alu_src2_imm_o = 1'b1;
        rs1_used_o     = 1'b1;
      end
      default: begin
        imm_type_o = IMM_RTYPE;
        illegal_o  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/decode_ctrl_pipe.sv
// Decode-stage controller: ID/EX control register with flush/stall/bubble,
// load-use hazard detection and a saturating bubble counter.
module decode_ctrl_pipe
  import decode_ctrl_pipe_pkg::*;
#(
  parameter int BUBBLE_CNT_W = 16
) (
  input  logic                    CPU_CLK,
  input  logic                    CPU_RST,
  input  logic [31:0]             InstD,
  input  logic                    ValidD,
  input  logic                    StallE,
  input  logic                    FlushE,
  output logic [2:0]              ImmTypeD,
  output logic [2:0]              ImmTypeE,
  output logic                    RegWriteE,
  output logic                    MemReadE,
  output logic                    MemWriteE,
  output logic                    BranchE,
  output logic                    JalE,
  output logic                    JalrE,
  output logic                    AluSrc2ImmE,
  output logic [4:0]              RdE,
  output logic [4:0]              Rs1E,
  output logic [4:0]              Rs2E,
  output logic                    ValidE,
  output logic                    IllegalE,
  output logic                    LoadUseStall,
  output logic [BUBBLE_CNT_W-1:0] BubbleCnt
);

  logic [2:0]              imm_type_s;
  ctrl_t                   ctrl_s;
  logic                    rs1_used_s;
  logic                    rs2_used_s;
  logic [4:0]              rd_d_s;
  logic [4:0]              rs1_d_s;
  logic [4:0]              rs2_d_s;
  logic                    load_use_s;
  logic                    unused_inst_s;
  logic [BUBBLE_CNT_W-1:0] cnt_inc_s;
  idex_t                   idex_d;
  idex_t                   idex_q;
  logic [BUBBLE_CNT_W-1:0] bubble_cnt_d;
  logic [BUBBLE_CNT_W-1:0] bubble_cnt_q;

  assign rd_d_s        = InstD[11:7];
  assign rs1_d_s       = InstD[19:15];
  assign rs2_d_s       = InstD[24:20];
  assign unused_inst_s = ^{InstD[31:25], InstD[14:12]};

  decode_ctrl_pipe_opcode_decoder u_opcode_decoder (
    .opcode_i       (InstD[6:0]),
    .imm_type_o     (imm_type_s),
    .reg_write_o    (ctrl_s.reg_write),
    .mem_read_o     (ctrl_s.mem_read),
    .mem_write_o    (ctrl_s.mem_write),
    .branch_o       (ctrl_s.branch),
    .jal_o          (ctrl_s.jal),
    .jalr_o         (ctrl_s.jalr),
    .alu_src2_imm_o (ctrl_s.alu_src2_imm),
    .illegal_o      (ctrl_s.illegal),
    .rs1_used_o     (rs1_used_s),
    .rs2_used_o     (rs2_used_s)
  );

  // Writes to x0 never produce a value, so a load to x0 cannot cause a hazard.
  assign load_use_s = idex_q.valid & idex_q.ctrl.mem_read & (idex_q.rd != 5'd0) & ValidD &
                      (src_match(rs1_used_s, rs1_d_s, idex_q.rd) |
                       src_match(rs2_used_s, rs2_d_s, idex_q.rd));

  assign cnt_inc_s = (bubble_cnt_q == {BUBBLE_CNT_W{1'b1}}) ? bubble_cnt_q
                   : bubble_cnt_q + {{(BUBBLE_CNT_W-1){1'b0}}, 1'b1};

  // ID/EX next state: flush beats stall, stall beats the load-use bubble.
  always_comb begin
    idex_d       = idex_q;
    bubble_cnt_d = bubble_cnt_q;
    if (FlushE) begin
      idex_d       = IDEX_BUBBLE;
      bubble_cnt_d = cnt_inc_s;
    end else if (StallE) begin
      idex_d       = idex_q;
      bubble_cnt_d = bubble_cnt_q;
    end else if (load_use_s) begin
      idex_d       = IDEX_BUBBLE;
      bubble_cnt_d = cnt_inc_s;
    end else if (ValidD) begin
      idex_d.imm_type = imm_type_e'(imm_type_s);
      idex_d.ctrl     = ctrl_s;
      idex_d.rd       = rd_d_s;
      idex_d.rs1      = rs1_d_s;
      idex_d.rs2      = rs2_d_s;
      idex_d.valid    = 1'b1;
    end else begin
      idex_d = IDEX_BUBBLE;
    end
  end

  // ID/EX control register and bubble counter.
  always_ff @(posedge CPU_CLK or posedge CPU_RST) begin
    if (CPU_RST) begin
      idex_q       <= IDEX_BUBBLE;
      bubble_cnt_q <= {BUBBLE_CNT_W{1'b0}};
    end else begin
      idex_q       <= idex_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign ImmTypeD     = imm_type_s;
  assign LoadUseStall = load_use_s;
  assign ImmTypeE     = idex_q.imm_type;
  assign RegWriteE    = idex_q.ctrl.reg_write;
  assign MemReadE     = idex_q.ctrl.mem_read;
  assign MemWriteE    = idex_q.ctrl.mem_write;
  assign BranchE      = idex_q.ctrl.branch;
  assign JalE         = idex_q.ctrl.jal;
  assign JalrE        = idex_q.ctrl.jalr;
  assign AluSrc2ImmE  = idex_q.ctrl.alu_src2_imm;
  assign IllegalE     = idex_q.ctrl.illegal;
  assign RdE          = idex_q.rd;
  assign Rs1E         = idex_q.rs1;
  assign Rs2E         = idex_q.rs2;
  assign ValidE       = idex_q.valid;
  assign BubbleCnt    = bubble_cnt_q;

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// Directed testbench for decode_ctrl_pipe with hand-computed expectations.
module tb_decode_ctrl_pipe;

  logic        CPU_CLK = 1'b0;
  logic        CPU_RST;
  logic [31:0] InstD;
  logic        ValidD;
  logic        StallE;
  logic        FlushE;
  logic [2:0]  ImmTypeD;
  logic [2:0]  ImmTypeE;
  logic        RegWriteE;
  logic        MemReadE;
  logic        MemWriteE;
  logic        BranchE;
  logic        JalE;
  logic        JalrE;
  logic        AluSrc2ImmE;
  logic [4:0]  RdE;
  logic [4:0]  Rs1E;
  logic [4:0]  Rs2E;
  logic        ValidE;
  logic        IllegalE;
  logic        LoadUseStall;
  logic [15:0] BubbleCnt;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [31:0] I_ADDI   = 32'h0051_0093; // addi x1,x2,5
  localparam logic [31:0] I_LW5    = 32'h0000_A283; // lw x5,0(x1)
  localparam logic [31:0] I_ADD    = 32'h0072_8333; // add x6,x5,x7
  localparam logic [31:0] I_LW0    = 32'h0000_A003; // lw x0,0(x1)
  localparam logic [31:0] I_ADD_X0 = 32'h0000_0333; // add x6,x0,x0
  localparam logic [31:0] I_SW     = 32'h0020_A023; // sw x2,0(x1)
  localparam logic [31:0] I_BAD    = 32'hFFFF_FFFF;

  decode_ctrl_pipe #(.BUBBLE_CNT_W(16)) dut (
    .CPU_CLK      (CPU_CLK),
    .CPU_RST      (CPU_RST),
    .InstD        (InstD),
    .ValidD       (ValidD),
    .StallE       (StallE),
    .FlushE       (FlushE),
    .ImmTypeD     (ImmTypeD),
    .ImmTypeE     (ImmTypeE),
    .RegWriteE    (RegWriteE),
    .MemReadE     (MemReadE),
    .MemWriteE    (MemWriteE),
    .BranchE      (BranchE),
    .JalE         (JalE),
    .JalrE        (JalrE),
    .AluSrc2ImmE  (AluSrc2ImmE),
    .RdE          (RdE),
    .Rs1E         (Rs1E),
    .Rs2E         (Rs2E),
    .ValidE       (ValidE),
    .IllegalE     (IllegalE),
    .LoadUseStall (LoadUseStall),
    .BubbleCnt    (BubbleCnt)
  );

  always #5 CPU_CLK = ~CPU_CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CPU_CLK);
    #1;
  endtask

  initial begin
    CPU_RST = 1'b1;
    InstD   = 32'h0;
    ValidD  = 1'b0;
    StallE  = 1'b0;
    FlushE  = 1'b0;
    #12;
    chk("rst_valid",    32'(ValidE),    32'd0);
    chk("rst_immtype",  32'(ImmTypeE),  32'd0);
    chk("rst_bubbles",  32'(BubbleCnt), 32'd0);
    chk("rst_regwrite", 32'(RegWriteE), 32'd0);

    // addi: combinational format select, then one-cycle latency to E
    InstD  = I_ADDI;
    ValidD = 1'b1;
    #1;
    chk("addi_immD", 32'(ImmTypeD), 32'd1);
    CPU_RST = 1'b0;
    tick();
    chk("addi_regwrite", 32'(RegWriteE),   32'd1);
    chk("addi_alusrc",   32'(AluSrc2ImmE), 32'd1);
    chk("addi_rd",       32'(RdE),         32'd1);
    chk("addi_rs1",      32'(Rs1E),        32'd2);
    chk("addi_valid",    32'(ValidE),      32'd1);
    chk("addi_immE",     32'(ImmTypeE),    32'd1);
    chk("addi_memread",  32'(MemReadE),    32'd0);

    // lw x5 then add reading x5: one bubble
    InstD = I_LW5;
    #1;
    chk("lw_nostall", 32'(LoadUseStall), 32'd0);
    tick();
    chk("lw_memread", 32'(MemReadE), 32'd1);
    chk("lw_rd",      32'(RdE),      32'd5);
    InstD = I_ADD;
    #1;
    chk("lu_stall", 32'(LoadUseStall), 32'd1);
    tick();
    chk("lu_bub_valid",    32'(ValidE),       32'd0);
    chk("lu_bub_regwrite", 32'(RegWriteE),    32'd0);
    chk("lu_bub_memread",  32'(MemReadE),     32'd0);
    chk("lu_bub_rd",       32'(RdE),          32'd0);
    chk("lu_bub_cnt",      32'(BubbleCnt),    32'd1);
    chk("lu_stall_drop",   32'(LoadUseStall), 32'd0);
    tick();
    chk("add_rd",    32'(RdE),       32'd6);
    chk("add_rs1",   32'(Rs1E),      32'd5);
    chk("add_rs2",   32'(Rs2E),      32'd7);
    chk("add_valid", 32'(ValidE),    32'd1);
    chk("add_cnt",   32'(BubbleCnt), 32'd1);

    // lw x0 never creates a hazard
    InstD = I_LW0;
    tick();
    chk("lw0_memread", 32'(MemReadE), 32'd1);
    InstD = I_ADD_X0;
    #1;
    chk("lw0_nostall", 32'(LoadUseStall), 32'd0);
    tick();
    chk("lw0_add_valid", 32'(ValidE),    32'd1);
    chk("lw0_add_rd",    32'(RdE),       32'd6);
    chk("lw0_cnt",       32'(BubbleCnt), 32'd1);

    // flush with stall and load-use all asserted
    InstD = I_LW5;
    tick();
    InstD  = I_ADD;
    StallE = 1'b1;
    FlushE = 1'b1;
    #1;
    chk("fl_stall_req", 32'(LoadUseStall), 32'd1);
    tick();
    chk("fl_valid",   32'(ValidE),    32'd0);
    chk("fl_memread", 32'(MemReadE),  32'd0);
    chk("fl_cnt",     32'(BubbleCnt), 32'd2);
    StallE = 1'b0;
    FlushE = 1'b0;
    #1;
    chk("fl_stall_drop", 32'(LoadUseStall), 32'd0);
    tick();
    chk("fl_add_rd", 32'(RdE), 32'd6);

    // store held through a 3-cycle stall
    InstD = I_SW;
    tick();
    chk("sw_memwrite", 32'(MemWriteE), 32'd1);
    chk("sw_immE",     32'(ImmTypeE),  32'd2);
    InstD  = I_ADDI;
    StallE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_memwrite", 32'(MemWriteE), 32'd1);
      chk("hold_immE",     32'(ImmTypeE),  32'd2);
      chk("hold_regwrite", 32'(RegWriteE), 32'd0);
      chk("hold_cnt",      32'(BubbleCnt), 32'd2);
    end
    StallE = 1'b0;

    // illegal opcode, valid and invalid
    InstD = I_BAD;
    #1;
    chk("bad_immD", 32'(ImmTypeD), 32'd0);
    tick();
    chk("bad_illegal",  32'(IllegalE),  32'd1);
    chk("bad_regwrite", 32'(RegWriteE), 32'd0);
    chk("bad_memwrite", 32'(MemWriteE), 32'd0);
    chk("bad_valid",    32'(ValidE),    32'd1);
    ValidD = 1'b0;
    tick();
    chk("badnv_illegal", 32'(IllegalE),  32'd0);
    chk("badnv_valid",   32'(ValidE),    32'd0);
    chk("badnv_cnt",     32'(BubbleCnt), 32'd2);

    // async reset during a stall, then a normal first load
    ValidD = 1'b1;
    InstD  = I_LW5;
    tick();
    InstD  = I_ADD;
    StallE = 1'b1;
    tick();
    chk("ms_memread", 32'(MemReadE),     32'd1);
    chk("ms_stall",   32'(LoadUseStall), 32'd1);
    #2;
    CPU_RST = 1'b1;
    #1;
    chk("ar_memread", 32'(MemReadE),     32'd0);
    chk("ar_valid",   32'(ValidE),       32'd0);
    chk("ar_rd",      32'(RdE),          32'd0);
    chk("ar_cnt",     32'(BubbleCnt),    32'd0);
    chk("ar_stall",   32'(LoadUseStall), 32'd0);
    StallE = 1'b0;
    InstD  = I_ADDI;
    #1;
    CPU_RST = 1'b0;
    tick();
    chk("post_rst_regwrite", 32'(RegWriteE), 32'd1);
    chk("post_rst_rd",       32'(RdE),       32'd1);
    chk("post_rst_valid",    32'(ValidE),    32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_ctrl_pipe.md
Name: decode_ctrl_pipe

Overview:
Decode-stage controller for the RV32I pipeline.
- Decodes the ID-stage instruction into the immediate-format select that steers the immediate generator, plus the control bundle for later stages.
- Registers the bundle into the ID/EX control register, with stall hold, flush and bubble insertion.
- Detects load-use hazards and raises a one-cycle stall request to the front end.
- Sits between the IF/ID register and the EX stage; the hazard unit consumes LoadUseStall.

Parameters:
BUBBLE_CNT_W, 16, width of the saturating bubble counter.

Ports:
CPU_CLK  in  1  core clock, rising edge.
CPU_RST  in  1  reset, asynchronous, active-high.
InstD  in  32  instruction in ID.
ValidD  in  1  InstD is a real instruction.
StallE  in  1  hold the ID/EX control register.
FlushE  in  1  replace ID/EX contents with a bubble.
ImmTypeD  out  3  immediate format select, combinational from InstD.
ImmTypeE  out  3  registered format select.
RegWriteE  out  1  EX-stage instruction writes rd.
MemReadE  out  1  EX-stage instruction is a load.
MemWriteE  out  1  EX-stage instruction is a store.
BranchE  out  1  EX-stage instruction is a conditional branch.
JalE  out  1  EX-stage instruction is JAL.
JalrE  out  1  EX-stage instruction is JALR.
AluSrc2ImmE  out  1  ALU operand 2 is the immediate.
RdE  out  5  destination register.
Rs1E, Rs2E  out  5 each  source registers (forwarding use).
ValidE  out  1  EX slot holds a real instruction.
IllegalE  out  1  EX slot holds an unknown opcode.
LoadUseStall  out  1  stall request, combinational.
BubbleCnt  out  BUBBLE_CNT_W  saturating count of bubbles inserted.

Behaviour:
- Immediate format encoding (shared constants): RTYPE=0, ITYPE=1, STYPE=2, BTYPE=3, UTYPE=4, JTYPE=5.
- Opcode decode from InstD[6:0]:
  - 0110011 -> RTYPE, RegWrite.
  - 0010011 -> ITYPE, RegWrite, AluSrc2Imm.
  - 0000011 -> ITYPE, RegWrite, MemRead, AluSrc2Imm.
  - 0100011 -> STYPE, MemWrite, AluSrc2Imm.
  - 1100011 -> BTYPE, Branch.
  - 0110111 / 0010111 -> UTYPE, RegWrite, AluSrc2Imm.
  - 1101111 -> JTYPE, RegWrite, Jal.
  - 1100111 -> ITYPE, RegWrite, Jalr, AluSrc2Imm.
  - Any other opcode -> RTYPE, all controls 0, Illegal=1.
- ImmTypeD is purely combinational; it is valid even when ValidD=0.
- Source-register usage:
  - rs1 used by R, I, S, B and JALR.
  - rs2 used by R, S and B.
  - U and J use neither.
- LoadUseStall = ValidE & MemReadE & (RdE!=0) & ValidD & ((rs1 used & Rs1D==RdE) | (rs2 used & Rs2D==RdE)).
- ID/EX update on each rising edge, in priority order:
  1. FlushE=1 -> bubble.
  2. Else StallE=1 -> hold all registers.
  3. Else LoadUseStall=1 -> bubble.
  4. Else load the decoded bundle, with ValidE=ValidD.
- A bubble means all control outputs 0, ValidE=0, RdE=Rs1E=Rs2E=0, ImmTypeE=RTYPE.
- ValidD=0 loads a bubble even when the opcode is illegal; IllegalE is set only when ValidD=1.
- Stall timing:
  - After a bubble is inserted, the load has left EX, so LoadUseStall deasserts in the next cycle.
  - Exactly one stall cycle occurs per hazard.
- BubbleCnt:
  - Increments by 1 on every edge that inserts a bubble because of LoadUseStall or FlushE.
  - Saturates at all-ones.
  - Holds its value while StallE=1 without FlushE.
- Reset: all registered outputs 0, ImmTypeE=RTYPE, BubbleCnt=0. Reset takes effect immediately and asynchronously, including mid-stall; the first post-reset edge behaves as a normal load.
- Latency: one cycle from ID to the E outputs.

Decomposition:
- Immediate-type and opcode constants belong in the shared parameters header.
- One sub-module, opcode_decoder, holds the combinational decode: InstD to format select, control bundle, rs-usage flags and illegal flag.
- The top level holds the hazard compare, the ID/EX register and the counter.

Test Plan:
- Reset released, InstD=0x00510093 (addi x1,x2,5), ValidD=1 -> ImmTypeD=1 immediately; next edge RegWriteE=1, AluSrc2ImmE=1, RdE=1, ValidE=1.
- lw x5,0(x1) (0x0000A283) followed by add x6,x5,x7 (0x00728333) -> LoadUseStall=1 for exactly one cycle; then ValidE=0 with all controls 0; BubbleCnt=1; on the next edge add enters E with RdE=6.
- lw x0,0(x1) (0x0000A003) followed by an add reading x0 -> LoadUseStall stays 0 and no bubble is inserted.
- FlushE=1 together with StallE=1 and LoadUseStall=1 -> bubble inserted; BubbleCnt increments by exactly 1.
- StallE=1 for 3 cycles with sw (0x0020A023) in E -> MemWriteE=1 and ImmTypeE=2 held constant; BubbleCnt unchanged.
- InstD=0xFFFFFFFF with ValidD=1 -> IllegalE=1, other controls 0; with ValidD=0 -> IllegalE=0. Assert CPU_RST mid-stall -> outputs clear before the next edge.
